// File: rtl/approx_pkg.sv
// Shared definitions for the truncated-low-bit approximate arithmetic library:
// operand/result widths and the exact and approximate subtraction references.
package approx_pkg;

  localparam int DATA_W = 12;
  localparam int RES_W  = 13;
  localparam int MAX_K  = DATA_W - 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [RES_W-1:0]  res_t;

  // Width of the error bus: at least one bit so K=0 still has a legal port.
  function automatic int err_width(input int k);
    return (k > 0) ? k : 1;
  endfunction

  // Mask selecting the low k result bits that bypass the subtractor.
  function automatic res_t low_mask(input int k);
    return (RES_W'(1) << k) - RES_W'(1);
  endfunction

  // Exact 13-bit difference; bit 12 is the borrow-out.
  function automatic res_t exact_sub(input data_t a, input data_t b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Approximate difference: the low k bits of A pass straight through and the
  // upper field is subtracted with no borrow-in from the low bits. Zeroing the
  // low bits of both operands before subtracting keeps the upper field's
  // arithmetic isolated, so one 13-bit subtract serves every k.
  function automatic res_t approx_sub(input data_t a, input data_t b, input int k);
    res_t mask;
    res_t hi_a;
    res_t hi_b;
    mask = low_mask(k);
    hi_a = {1'b0, a} & ~mask;
    hi_b = {1'b0, b} & ~mask;
    return (hi_a - hi_b) | ({1'b0, a} & mask);
  endfunction

endpackage

// File: rtl/approx_err_stats.sv
// Error statistics for characterisation runs: running maximum of err and a
// saturating count of results that carried a nonzero error.
module approx_err_stats #(
  parameter int ERR_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             xfer,
  input  logic [ERR_W-1:0] err,
  output logic [ERR_W-1:0] err_max,
  output logic [CNT_W-1:0] err_cnt
);

  // Clear outranks a coincident transfer so a characterisation window starts
  // with exactly zero counted results.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_max <= '0;
      err_cnt <= '0;
    end else if (xfer) begin
      if (err > err_max) begin
        err_max <= err;
      end
      if ((err != '0) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/approx_sub12u_pipe.sv
// Two-stage pipelined 12-bit unsigned approximate subtractor with valid/ready
// handshakes on both sides and a built-in error monitor.
module approx_sub12u_pipe
  import approx_pkg::*;
#(
  parameter  int APPROX_BITS = 4,
  parameter  int CNT_W       = 16,
  localparam int ERR_W       = (APPROX_BITS > 0) ? APPROX_BITS : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  O,
  output logic [ERR_W-1:0]  err,
  input  logic              stats_clr,
  output logic [ERR_W-1:0]  err_max,
  output logic [CNT_W-1:0]  err_cnt
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_advance;
  logic             in_xfer;
  logic             out_xfer;
  data_t            s1_a;
  data_t            s1_b;
  res_t             s1_approx;
  res_t             s1_exact;
  logic [ERR_W-1:0] s1_err;
  res_t             s2_o;
  logic [ERR_W-1:0] s2_err;

  // Handshake: stage 1 may move on whenever stage 2 is empty or draining.
  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = s2_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s1_approx = '0;
    s1_exact  = '0;
    s1_err    = '0;
    s1_approx = approx_sub(s1_a, s1_b, APPROX_BITS);
    s1_exact  = exact_sub(s1_a, s1_b);
    // Measured rather than hardwired so the monitor catches datapath faults.
    s1_err    = ERR_W'(s1_approx - s1_exact);
  end

  // NOTE: sequential state uses non-blocking assignments only; control and
  // visible outputs are reset, pure payload registers are not.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_o     <= '0;
      s2_err   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_o   <= s1_approx;
          s2_err <= s1_err;
        end
      end
    end
  end

  // NOTE: operand registers carry no reset; s1_valid qualifies their contents.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_a <= A;
      s1_b <= B;
    end
  end

  assign out_valid = s2_valid;
  assign O         = s2_o;
  assign err       = s2_err;

  approx_err_stats #(
    .ERR_W (ERR_W),
    .CNT_W (CNT_W)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .clr     (stats_clr),
    .xfer    (out_xfer),
    .err     (s2_err),
    .err_max (err_max),
    .err_cnt (err_cnt)
  );

endmodule

// File: tb/tb_approx_sub12u_pipe.sv
// Scoreboard bench: a K=4/CNT_W=4 instance and a K=0 instance share all inputs;
// expected results are queued at input transfer and compared at output transfer.
module tb_approx_sub12u_pipe;
  import approx_pkg::*;

  localparam int K     = 4;
  localparam int CNT_W = 4;

  typedef struct {
    res_t       o;
    logic [3:0] err;
    res_t       o0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       stats_clr;
  data_t      a_in;
  data_t      b_in;

  logic       in_ready,  in_ready0;
  logic       out_valid, out_valid0;
  res_t       o_out,     o_out0;
  logic [3:0] err,       err_max;
  logic [3:0] err_cnt;
  logic       err0,      err_max0;
  logic [15:0] err_cnt0;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   xfer_total = 0;
  int   max_run = 0;

  approx_sub12u_pipe #(.APPROX_BITS(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .O(o_out), .err(err), .stats_clr(stats_clr),
    .err_max(err_max), .err_cnt(err_cnt)
  );

  approx_sub12u_pipe #(.APPROX_BITS(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a_in), .B(b_in), .out_valid(out_valid0), .out_ready(out_ready),
    .O(o_out0), .err(err0), .stats_clr(stats_clr),
    .err_max(err_max0), .err_cnt(err_cnt0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one operand pair and waits (bounded) for it to be accepted.
  task automatic send(input data_t a, input data_t b);
    exp_t e;
    bit   accepted = 1'b0;
    int   n = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    while (!accepted && n < 50) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        e.o   = approx_sub(a, b, K);
        e.err = b[3:0];
        e.o0  = exact_sub(a, b);
        sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accept", 32'(accepted), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  // Output monitor and statistics model, sampled on the falling edge.
  initial begin : monitor
    exp_t       e;
    logic [3:0] m_max = '0;
    logic [3:0] m_cnt = '0;
    bit         stall_prev = 1'b0;
    res_t       hold_o = '0;
    logic [3:0] hold_err = '0;
    int         run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_max = '0;
        m_cnt = '0;
        stall_prev = 1'b0;
        run = 0;
      end else begin
        check("err_max", 32'(err_max), 32'(m_max));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
        check("in_ready_k0", 32'(in_ready0), 32'(in_ready));
        if (stall_prev) begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_o", 32'(o_out), 32'(hold_o));
          check("stall_err", 32'(err), 32'(hold_err));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 32'(o_out), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("o", 32'(o_out), 32'(e.o));
            check("err", 32'(err), 32'(e.err));
            check("valid_k0", 32'(out_valid0), 1);
            check("o_k0", 32'(o_out0), 32'(e.o0));
            check("err_k0", 32'(err0), 0);
            if (stats_clr) begin
              m_max = '0;
              m_cnt = '0;
            end else begin
              if (e.err > m_max) m_max = e.err;
              if (e.err != 0 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            end
          end
          xfer_total++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
          if (stats_clr) begin
            m_max = '0;
            m_cnt = '0;
          end
        end
        stall_prev = out_valid && !out_ready;
        hold_o     = o_out;
        hold_err   = err;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t0;
    int x0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
    a_in = '0; b_in = '0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_o", 32'(o_out), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_max", 32'(err_max), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;

    // First result: latency and known values.
    send(12'h123, 12'h045);
    @(negedge clk);
    check("lat1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat2_valid", 32'(out_valid), 1);
    check("t1_o", 32'(o_out), 'h00E3);
    check("t1_err", 32'(err), 5);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_err_cnt", 32'(err_cnt), 1);
    check("t1_err_max", 32'(err_max), 5);
    @(posedge clk); #1;

    // Negative difference: borrow-out set, zero error.
    send(12'h010, 12'h020);
    cycles(1);
    @(negedge clk);
    check("t2_o", 32'(o_out), 'h1FF0);
    check("t2_err", 32'(err), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_err_cnt", 32'(err_cnt), 1);
    @(posedge clk); #1;

    // Back-to-back throughput.
    max_run = 0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(data_t'($urandom), data_t'($urandom));
    check("b2b_cycles", 32'(cyc - t0), 8);
    drain();
    check("b2b_run", 32'(max_run), 8);

    // Stall with both stages full, then release.
    x0 = xfer_total;
    out_ready = 1'b0;
    send(data_t'($urandom), data_t'($urandom));
    send(data_t'($urandom), data_t'($urandom));
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    cycles(4);
    @(negedge clk);
    check("full_in_ready2", 32'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(data_t'($urandom), data_t'($urandom));
    drain();
    check("stall_xfers", 32'(xfer_total - x0), 3);

    // Saturation with a 4-bit counter.
    stats_clr = 1'b1;
    cycles(1);
    stats_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_t rb;
      rb = data_t'($urandom);
      send(data_t'($urandom), {rb[11:4], 4'hF});
    end
    drain();
    @(negedge clk);
    check("sat_err_max", 32'(err_max), 15);
    check("sat_err_cnt", 32'(err_cnt), 15);
    @(posedge clk); #1;

    // Clear coinciding with a transfer carrying err=7.
    send(12'h500, 12'h107);
    cycles(1);
    stats_clr = 1'b1;
    @(negedge clk);
    check("clr_xfer_valid", 32'(out_valid), 1);
    check("clr_xfer_err", 32'(err), 7);
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    check("clr_err_max", 32'(err_max), 0);
    check("clr_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;

    // Reset with both stages full; in_valid during reset must be ignored.
    send(12'h0AB, 12'h00C);
    drain();
    out_ready = 1'b0;
    send(data_t'($urandom), data_t'($urandom));
    send(data_t'($urandom), data_t'($urandom));
    @(negedge clk);
    check("pre_rst_in_ready", 32'(in_ready), 0);
    check("pre_rst_err_max", 32'(err_max), 12);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    a_in = 12'h777;
    b_in = 12'h111;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_err_max", 32'(err_max), 0);
    check("mid_rst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    x0 = xfer_total;
    cycles(4);
    check("mid_rst_no_out", 32'(xfer_total - x0), 0);

    // Random sweep; the K=0 instance must be exact throughout.
    for (int i = 0; i < 1000; i++) send(data_t'($urandom), data_t'($urandom));
    drain();
    @(negedge clk);
    check("k0_err_max", 32'(err_max0), 0);
    check("k0_err_cnt", 32'(err_cnt0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_sub12u_pipe.md
Name: approx_sub12u_pipe

Overview:
- Two-stage pipelined 12-bit unsigned approximate subtractor with valid/ready handshakes on both sides.
- It is the inverse-operation counterpart of the library's truncated-low-bit approximate adders and uses the same approximation style: the low K bits are passed straight through and carry no borrow.
- Built-in error monitor tracks worst-case and nonzero-error counts against the exact difference, for on-FPGA characterisation runs.

Parameters:
- APPROX_BITS, 4, number of low bits approximated (K); legal range 0..11; 0 gives an exact subtractor.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- A  in  12  minuend (unsigned).
- B  in  12  subtrahend (unsigned).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- O  out  13  approximate difference; O[12] is the borrow-out (two's-complement sign of the 13-bit result).
- err  out  APPROX_BITS (min 1)  |exact − approx| for the current output.
- stats_clr  in  1  synchronous clear of the statistics.
- err_max  out  APPROX_BITS (min 1)  largest err seen since reset/clear.
- err_cnt  out  CNT_W  number of transferred results with err≠0; saturates at all-ones.

Behaviour:
- Arithmetic, with K=APPROX_BITS:
  - O[K-1:0] = A[K-1:0].
  - O[12:K] = A[11:K] − B[11:K], borrow-in 0, computed 13−K bits wide.
  - Exact reference E = A − B mod 2^13.
  - Error is always B[K-1:0], range 0..2^K−1. It is computed as E subtracted from O mod 2^13; it is not hardwired.
  - K=0: O==E and err==0.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || out_ready.
  - in_ready may depend combinationally on out_ready; it does not depend on in_valid.
- Pipeline:
  - S1 registers A and B and computes the exact and approximate results.
  - S2 registers O and err; out_valid = s2_valid.
  - Latency is 2 cycles from input transfer to out_valid. Throughput is 1 result per cycle when out_ready is held high.
  - Stall: while out_valid && !out_ready, O and err are held stable and no data is lost or duplicated. Both stages may be full; in_ready is then 0.
- Statistics update on each output transfer:
  - err_max = max(err_max, err).
  - err_cnt is incremented if err≠0 and the counter is not saturated.
  - stats_clr has priority: when it coincides with a transfer, the statistics go to 0 and that transfer is not counted.
- Reset:
  - Values: s1_valid=0, s2_valid=0, out_valid=0, in_ready=1 (after reset), O=0, err=0, err_max=0, err_cnt=0.
  - Reset mid-operation drops in-flight data with no output transfer.
  - Any in_valid asserted in the reset cycle is ignored.

Decomposition:
- Shared package approx_pkg:
  - localparam DATA_W=12 and RES_W=13.
  - Function approx_sub(a, b, k) returning the 13-bit approximate result.
  - Function exact_sub(a, b).
  - Both functions are reused by the bench's scoreboard.
- One sub-module, approx_err_stats: err_max and saturating err_cnt with clear priority.
- Pipeline control and datapath stay in the top.

Test Plan:
- K=4, A=0x123, B=0x045, out_ready=1 -> after 2 cycles O=0x00E3, err=5, err_cnt=1, err_max=5.
- K=4, A=0x010, B=0x020 -> O=0x1FF0 (borrow=1), err=0, err_cnt unchanged.
- Back-to-back 8 random pairs, out_ready=1 -> 8 consecutive out_valid cycles, each O equals approx_sub. Then hold out_ready=0 for 5 cycles -> O stable, in_ready=0 once both stages are full, no loss or duplication after release.
- B low nibble=0xF on 20 transfers with CNT_W=4 -> err_max=15, err_cnt saturates at 15.
- stats_clr asserted in the same cycle as a transfer with err=7 -> err_max=0, err_cnt=0 the next cycle.
- rst asserted while both stages are full -> next cycle out_valid=0, in_ready=1, statistics 0. Also K=0 sweep of 1000 random pairs -> err always 0 and O==A−B mod 2^13.
